// File: rtl/servo_cmd_pkg.sv
// Shared constants, state encoding and ASCII helpers
// for the servo command parser.
package servo_cmd_pkg;

  localparam int TICKS_PER_US   = 27;
  localparam int US_MIN         = 300;
  localparam int US_MAX         = 2500;
  localparam int US_DEFAULT     = 1500;
  localparam int MAX_DIGITS     = 4;
  localparam int TIMEOUT_CYCLES = 2700000;

  localparam logic [7:0] CH_S_UP = 8'h53;
  localparam logic [7:0] CH_S_LO = 8'h73;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_NINE = 8'h39;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIGITS = 2'd1,
    ST_CONV   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_ZERO) && (b <= CH_NINE);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

  function automatic logic is_start(input logic [7:0] b);
    return (b == CH_S_UP) || (b == CH_S_LO);
  endfunction

endpackage

// File: rtl/servo_cmd_parser_if.sv
// Byte stream in, pulse width and status out.
// master = byte source / consumer, slave = parser.
interface servo_cmd_if;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [19:0] pwm_width;
  logic        cmd_valid;
  logic        cmd_err;
  logic        busy;

  modport master (
    output rx_valid,
    output rx_data,
    input  pwm_width,
    input  cmd_valid,
    input  cmd_err,
    input  busy
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output pwm_width,
    output cmd_valid,
    output cmd_err,
    output busy
  );

endinterface

// File: rtl/servo_cmd_parser_us_to_ticks.sv
// Clamp a microsecond value to the servo range and
// scale it to clock ticks (combinational).
module us_to_ticks
  import servo_cmd_pkg::*;
#(
  parameter int US_LO = US_MIN,
  parameter int US_HI = US_MAX,
  parameter int TPU   = TICKS_PER_US
) (
  input  logic [13:0] us,
  output logic [19:0] ticks
);

  logic [19:0] c;

  // saturate into [US_LO, US_HI]
  always_comb begin
    c = {6'd0, us};
    if (us < 14'(US_LO)) begin
      c = 20'(US_LO);
    end else if (us > 14'(US_HI)) begin
      c = 20'(US_HI);
    end
  end

  // 27 = 16 + 8 + 2 + 1, so no multiplier is needed
  generate
    if (TPU == 27) begin : g_shift
      assign ticks = (c << 4) + (c << 3) + (c << 1) + c;
    end else begin : g_mul
      assign ticks = 20'(c * TPU);
    end
  endgenerate

endmodule

// File: rtl/servo_cmd_parser.sv
// ASCII "S<digits><CR|LF>" parser driving servo pulse width.
// Optional idle abort: define SERVO_CMD_TIMEOUT_EN.
module servo_cmd_parser
  import servo_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES_P = TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  servo_cmd_if.slave  bus
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [19:0] PWM_RST =
    20'(US_DEFAULT * TICKS_PER_US);

  state_t        state;
  state_t        state_n;
  logic [13:0]   acc;
  logic [13:0]   acc_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [19:0]   pwm;
  logic [19:0]   ticks;
  logic          valid_q;
  logic          valid_n;
  logic          err_q;
  logic          err_n;
  logic          load;
  logic          timeout;
  logic          in_frame;
  logic [7:0]    b;
  logic [13:0]   dig;

  assign b        = bus.rx_data;
  assign dig      = {10'd0, bus.rx_data[3:0]};
  assign in_frame = (state == ST_DIGITS) ||
                    (state == ST_FLUSH);

`ifdef SERVO_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES_P + 1);
  logic [TW-1:0] idle_cnt;

  // count consecutive quiet cycles inside a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (bus.rx_valid || !in_frame) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout = in_frame && !bus.rx_valid &&
    (idle_cnt == TW'(TIMEOUT_CYCLES_P - 1));
`else
  assign timeout = 1'b0;
`endif

  us_to_ticks u_conv (
    .us    (acc),
    .ticks (ticks)
  );

  // next-state, accumulator and pulse decode
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    valid_n = 1'b0;
    err_n   = 1'b0;
    load    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.rx_valid && is_start(b)) begin
          state_n = ST_DIGITS;
          acc_n   = '0;
          cnt_n   = '0;
        end
      end
      ST_DIGITS: begin
        if (bus.rx_valid) begin
          if (is_digit(b)) begin
            if (cnt == CW'(MAX_DIGITS)) begin
              err_n   = 1'b1;
              state_n = ST_FLUSH;
            end else begin
              acc_n = (acc << 3) + (acc << 1) + dig;
              cnt_n = cnt + 1'b1;
            end
          end else if (is_term(b)) begin
            if (cnt != '0) begin
              state_n = ST_CONV;
            end else begin
              err_n   = 1'b1;
              state_n = ST_IDLE;
            end
          end else if (is_start(b)) begin
            acc_n = '0;
            cnt_n = '0;
          end else begin
            err_n   = 1'b1;
            state_n = ST_FLUSH;
          end
        end else if (timeout) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_CONV: begin
        load    = 1'b1;
        valid_n = 1'b1;
        state_n = ST_IDLE;
      end
      ST_FLUSH: begin
        if (bus.rx_valid && is_term(b)) begin
          state_n = ST_IDLE;
        end else if (timeout) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // state, datapath and registered output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      pwm     <= PWM_RST;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      valid_q <= valid_n;
      err_q   <= err_n;
      if (load) begin
        pwm <= ticks;
      end
    end
  end

  assign bus.pwm_width = pwm;
  assign bus.cmd_valid = valid_q;
  assign bus.cmd_err   = err_q;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_servo_cmd_parser.sv
// Randomized bench for servo_cmd_parser with a
// frame-level reference model.
module tb_servo_cmd_parser;

  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  servo_cmd_if bus ();

  servo_cmd_parser #(
    .TIMEOUT_CYCLES_P (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int nv = 0;
  int ne = 0;

  int exp_nv = 0;
  int exp_ne = 0;
  int exp_pwm = 40500;
  bit m_open = 0;
  bit m_flush = 0;
  bit m_conv = 0;
  int m_val = 0;
  int m_cnt = 0;

  // pulse counters and mutual exclusion
  always @(posedge clk) begin
    if (bus.cmd_valid === 1'b1) nv++;
    if (bus.cmd_err === 1'b1) ne++;
    if (bus.cmd_valid === 1'b1 || bus.cmd_err === 1'b1) begin
      checks++;
      if (bus.cmd_valid === 1'b1 && bus.cmd_err === 1'b1) begin
        errors++;
        $display("FAIL excl: valid=%b err=%b want not both",
                 bus.cmd_valid, bus.cmd_err);
      end
    end
  end

  function automatic int clamp_ticks(input int v);
    int c;
    c = (v < 300) ? 300 : ((v > 2500) ? 2500 : v);
    return c * 27;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit adj);
    bit dig;
    bit term;
    bit st;
    dig  = (b >= "0") && (b <= "9");
    term = (b == 8'h0D) || (b == 8'h0A);
    st   = (b == "S") || (b == "s");
    if (adj && m_conv) begin
      m_conv = 0;
      return;
    end
    m_conv = 0;
    if (m_flush) begin
      if (term) m_flush = 0;
    end else if (!m_open) begin
      if (st) begin
        m_open = 1; m_val = 0; m_cnt = 0;
      end
    end else if (dig) begin
      if (m_cnt == 4) begin
        exp_ne++; m_open = 0; m_flush = 1;
      end else begin
        m_val = m_val * 10 + int'(b - 8'h30);
        m_cnt++;
      end
    end else if (term) begin
      m_open = 0;
      if (m_cnt == 0) begin
        exp_ne++;
      end else begin
        exp_nv++;
        exp_pwm = clamp_ticks(m_val);
        m_conv = 1;
      end
    end else if (st) begin
      m_val = 0; m_cnt = 0;
    end else begin
      exp_ne++; m_open = 0; m_flush = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    model_byte(b, 0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic send_burst(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = s[i];
      model_byte(s[i], i > 0);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (bus.pwm_width !== 20'd40500) begin
      errors++;
      $display("FAIL rst_pwm: got %0d want 40500", bus.pwm_width);
    end
    if (bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b want 0", bus.cmd_valid);
    end
    if (bus.cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err: got %b want 0", bus.cmd_err);
    end
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_latency();
    send_str("S2000");
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h0A;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    model_byte(8'h0A, 0);
    checks += 2;
    if (bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_n1_valid: got %b want 0", bus.cmd_valid);
    end
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_n1_busy: got %b want 1", bus.busy);
    end
    @(negedge clk);
    checks += 3;
    if (bus.cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL lat_n2_valid: got %b want 1", bus.cmd_valid);
    end
    if (bus.pwm_width !== 20'd54000) begin
      errors++;
      $display("FAIL lat_pwm: got %0d want 54000", bus.pwm_width);
    end
    if (bus.cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL lat_err: got %b want 0", bus.cmd_err);
    end
    @(negedge clk);
    checks += 2;
    if (bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_n3_valid: got %b want 0", bus.cmd_valid);
    end
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL lat_n3_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_frames(input string name, input string s[$]);
    foreach (s[i]) begin
      send_str(s[i]);
      settle();
      checks += 4;
      if (bus.pwm_width !== 20'(exp_pwm)) begin
        errors++;
        $display("FAIL %s_pwm[%0d]: got %0d want %0d",
                 name, i, bus.pwm_width, exp_pwm);
      end
      if (nv !== exp_nv) begin
        errors++;
        $display("FAIL %s_nvalid[%0d]: got %0d want %0d",
                 name, i, nv, exp_nv);
      end
      if (ne !== exp_ne) begin
        errors++;
        $display("FAIL %s_nerr[%0d]: got %0d want %0d",
                 name, i, ne, exp_ne);
      end
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy[%0d]: got %b want 0",
                 name, i, bus.busy);
      end
    end
  endtask

  task automatic test_clamp();
    test_frames("clamp", '{"S9999\r", "S100\n", "S2500\n",
                           "S2501\r\n", "S300\n", "s0\n", "S0299\n"});
    checks++;
    if (bus.pwm_width !== 20'd8100) begin
      errors++;
      $display("FAIL clamp_low: got %0d want 8100", bus.pwm_width);
    end
  endtask

  task automatic test_errors();
    test_frames("err", '{"S12a4\n", "S1500\n", "S12345\n", "S\n",
                         "S1S800\n", "xyz\n", "S7\rabc\n"});
  endtask

  task automatic test_back_to_back();
    send_burst("S2000\nS100\n");
    settle();
    send_burst("S700\r\n");
    settle();
    checks += 3;
    if (bus.pwm_width !== 20'(exp_pwm)) begin
      errors++;
      $display("FAIL b2b_pwm: got %0d want %0d", bus.pwm_width, exp_pwm);
    end
    if (nv !== exp_nv) begin
      errors++;
      $display("FAIL b2b_nvalid: got %0d want %0d", nv, exp_nv);
    end
    if (ne !== exp_ne) begin
      errors++;
      $display("FAIL b2b_nerr: got %0d want %0d", ne, exp_ne);
    end
  endtask

  function automatic logic [7:0] rstart();
    return ($urandom_range(0, 1) != 0) ? 8'h53 : 8'h73;
  endfunction

  function automatic logic [7:0] rdig();
    return 8'(8'h30 + $urandom_range(0, 9));
  endfunction

  task automatic test_random();
    logic [7:0] q[$];
    int k;
    for (int f = 0; f < 60; f++) begin
      q = {};
      k = $urandom_range(0, 5);
      case (k)
        0: begin
          q.push_back(rstart());
          repeat ($urandom_range(1, 4)) q.push_back(rdig());
        end
        1: begin
          q.push_back(rstart());
          repeat ($urandom_range(5, 6)) q.push_back(rdig());
        end
        2: q.push_back(rstart());
        3: begin
          q.push_back(rstart());
          q.push_back(rdig());
          q.push_back(8'h23);
          q.push_back(rdig());
        end
        4: begin
          q.push_back(rstart());
          q.push_back(rdig());
          q.push_back(rdig());
          q.push_back(rstart());
          repeat ($urandom_range(1, 4)) q.push_back(rdig());
        end
        default: begin
          q.push_back(8'h78);
          q.push_back(8'h0A);
          q.push_back(rstart());
          repeat (3) q.push_back(rdig());
        end
      endcase
      q.push_back(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
      if ($urandom_range(0, 3) == 0) q.push_back(8'h0A);
      send_q(q);
      settle();
      checks += 3;
      if (bus.pwm_width !== 20'(exp_pwm)) begin
        errors++;
        $display("FAIL rnd_pwm[%0d]: got %0d want %0d",
                 f, bus.pwm_width, exp_pwm);
      end
      if (nv !== exp_nv) begin
        errors++;
        $display("FAIL rnd_nvalid[%0d]: got %0d want %0d", f, nv, exp_nv);
      end
      if (ne !== exp_ne) begin
        errors++;
        $display("FAIL rnd_nerr[%0d]: got %0d want %0d", f, ne, exp_ne);
      end
    end
  endtask

  task automatic test_midframe_reset();
    send_str("S2000\n");
    settle();
    send_str("S12");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pwm = 40500;
    m_open = 0;
    m_flush = 0;
    m_conv = 0;
    checks += 2;
    if (bus.pwm_width !== 20'd40500) begin
      errors++;
      $display("FAIL mrst_pwm: got %0d want 40500", bus.pwm_width);
    end
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mrst_busy: got %b want 0", bus.busy);
    end
    send_str("\n");
    settle();
    checks += 2;
    if (nv !== exp_nv) begin
      errors++;
      $display("FAIL mrst_nvalid: got %0d want %0d", nv, exp_nv);
    end
    if (bus.pwm_width !== 20'd40500) begin
      errors++;
      $display("FAIL mrst_hold: got %0d want 40500", bus.pwm_width);
    end
  endtask

  task automatic test_timeout();
    int waited;
    send_str("S15");
`ifdef SERVO_CMD_TIMEOUT_EN
    waited = 0;
    while (bus.busy === 1'b1 && waited < TO + 20) begin
      @(negedge clk);
      waited++;
    end
    checks += 2;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL to_busy: got %b want 0 after %0d cycles",
               bus.busy, waited);
    end
    if (waited !== TO) begin
      errors++;
      $display("FAIL to_cycles: got %0d want %0d", waited, TO);
    end
    exp_ne++;
    m_open = 0;
    m_flush = 0;
    settle();
    send_str("00\n");
`else
    repeat (300) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL nto_busy: got %b want 1", bus.busy);
    end
    send_str("\n");
`endif
    settle();
    checks += 3;
    if (bus.pwm_width !== 20'(exp_pwm)) begin
      errors++;
      $display("FAIL to_pwm: got %0d want %0d", bus.pwm_width, exp_pwm);
    end
    if (nv !== exp_nv) begin
      errors++;
      $display("FAIL to_nvalid: got %0d want %0d", nv, exp_nv);
    end
    if (ne !== exp_ne) begin
      errors++;
      $display("FAIL to_nerr: got %0d want %0d", ne, exp_ne);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_clamp();
    test_errors();
    test_back_to_back();
    test_random();
    test_midframe_reset();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
